// File: rtl/hub75_rx_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_rx_monitor_if
//  Description : HUB75 panel-side inputs and decoded monitor outputs.
//                The master drives the panel lines; the monitor is the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface hub75_rx_monitor_if #(
    parameter int ON_W = 16
);
    // Panel lines (asynchronous to the monitor clock) and error clear
    logic            hclk_in;
    logic            latch_in;
    logic            oe_in;
    logic [5:0]      rgb_in;
    logic [4:0]      addr_in;
    logic            err_clr;

    // Decoded pixel / line reports
    logic            pix_valid;
    logic [6:0]      pix_col;
    logic [5:0]      pix_rgb;
    logic            line_valid;
    logic [4:0]      line_row;
    logic [6:0]      line_count;
    logic [ON_W-1:0] on_cycles;
    logic            err_len;
    logic            err_oe;

    modport master (
        output hclk_in, latch_in, oe_in, rgb_in, addr_in, err_clr,
        input  pix_valid, pix_col, pix_rgb, line_valid, line_row,
               line_count, on_cycles, err_len, err_oe
    );

    modport slave (
        input  hclk_in, latch_in, oe_in, rgb_in, addr_in, err_clr,
        output pix_valid, pix_col, pix_rgb, line_valid, line_row,
               line_count, on_cycles, err_len, err_oe
    );
endinterface
`default_nettype wire

// File: rtl/hub75_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_rx_monitor
//  Description : Passive HUB75 receive monitor. Synchronizes the panel lines,
//                reports every captured pixel, per-line pixel counts, OE
//                on-time between latches and sticky length / OE errors.
//  Revision    : 1.0  initial release
// ============================================================================
module hub75_rx_monitor #(
    parameter int COLS = 64,
    parameter int ON_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    hub75_rx_monitor_if.slave bus
);

    // Column counter is 8 bits so that COLS+1 fits even for COLS = 127
    localparam logic [7:0]      C_COLS     = 8'(COLS);
    localparam logic [7:0]      C_COLS_SAT = 8'(COLS + 1);
    localparam logic [ON_W-1:0] C_ON_MAX   = '1;
    localparam logic [ON_W-1:0] C_ON_ONE   = ON_W'(1);

    // Synchronizer stages
    logic       hclk_s1_q, hclk_s2_q, hclk_s3_q;
    logic       latch_s1_q, latch_s2_q, latch_s3_q;
    logic       oe_s1_q, oe_s2_q;
    logic [5:0] rgb_s1_q, rgb_s2_q;
    logic [4:0] addr_s1_q, addr_s2_q;

    // Counters and output registers
    logic [7:0]      col_cnt_q, col_cnt_d;
    logic [ON_W-1:0] on_cnt_q, on_cnt_d;
    logic            pix_valid_q, pix_valid_d;
    logic [6:0]      pix_col_q, pix_col_d;
    logic [5:0]      pix_rgb_q, pix_rgb_d;
    logic            line_valid_q, line_valid_d;
    logic [4:0]      line_row_q, line_row_d;
    logic [6:0]      line_count_q, line_count_d;
    logic [ON_W-1:0] on_cycles_q, on_cycles_d;
    logic            err_len_q, err_len_d;
    logic            err_oe_q, err_oe_d;

    logic w_hclk_rise;
    logic w_latch_rise;

    assign w_hclk_rise  = hclk_s2_q & ~hclk_s3_q;
    assign w_latch_rise = latch_s2_q & ~latch_s3_q;

    // Bring all panel lines into the clk domain; hclk/latch get a third stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hclk_s1_q  <= 1'b0;
            hclk_s2_q  <= 1'b0;
            hclk_s3_q  <= 1'b0;
            latch_s1_q <= 1'b0;
            latch_s2_q <= 1'b0;
            latch_s3_q <= 1'b0;
            oe_s1_q    <= 1'b0;
            oe_s2_q    <= 1'b0;
            rgb_s1_q   <= 6'd0;
            rgb_s2_q   <= 6'd0;
            addr_s1_q  <= 5'd0;
            addr_s2_q  <= 5'd0;
        end else begin
            hclk_s1_q  <= bus.hclk_in;
            hclk_s2_q  <= hclk_s1_q;
            hclk_s3_q  <= hclk_s2_q;
            latch_s1_q <= bus.latch_in;
            latch_s2_q <= latch_s1_q;
            latch_s3_q <= latch_s2_q;
            oe_s1_q    <= bus.oe_in;
            oe_s2_q    <= oe_s1_q;
            rgb_s1_q   <= bus.rgb_in;
            rgb_s2_q   <= rgb_s1_q;
            addr_s1_q  <= bus.addr_in;
            addr_s2_q  <= addr_s1_q;
        end
    end

    // Pixel capture, line closing, OE on-time and sticky error next-state.
    // The pixel path runs first so a coincident latch sees the updated count.
    always_comb begin
        col_cnt_d    = col_cnt_q;
        on_cnt_d     = on_cnt_q;
        pix_valid_d  = 1'b0;
        pix_col_d    = pix_col_q;
        pix_rgb_d    = pix_rgb_q;
        line_valid_d = 1'b0;
        line_row_d   = line_row_q;
        line_count_d = line_count_q;
        on_cycles_d  = on_cycles_q;
        err_len_d    = err_len_q & ~bus.err_clr;
        err_oe_d     = err_oe_q & ~bus.err_clr;

        if (w_hclk_rise) begin
            if (col_cnt_q < C_COLS) begin
                pix_valid_d = 1'b1;
                pix_col_d   = col_cnt_q[6:0];
                pix_rgb_d   = rgb_s2_q;
                col_cnt_d   = col_cnt_q + 8'd1;
            end else if (col_cnt_q < C_COLS_SAT) begin
                col_cnt_d   = col_cnt_q + 8'd1;
            end
        end

        if (!oe_s2_q && (on_cnt_q != C_ON_MAX)) begin
            on_cnt_d = on_cnt_q + C_ON_ONE;
        end

        if (w_latch_rise) begin
            line_valid_d = 1'b1;
            line_row_d   = addr_s2_q;
            // Only reachable with COLS = 127: clamp to the 7-bit output range
            line_count_d = col_cnt_d[7] ? 7'h7f : col_cnt_d[6:0];
            on_cycles_d  = on_cnt_d;
            if (col_cnt_d != C_COLS) begin
                err_len_d = 1'b1;
            end
            if (!oe_s2_q) begin
                err_oe_d = 1'b1;
            end
            col_cnt_d = 8'd0;
            on_cnt_d  = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q    <= 8'd0;
            on_cnt_q     <= '0;
            pix_valid_q  <= 1'b0;
            pix_col_q    <= 7'd0;
            pix_rgb_q    <= 6'd0;
            line_valid_q <= 1'b0;
            line_row_q   <= 5'd0;
            line_count_q <= 7'd0;
            on_cycles_q  <= '0;
            err_len_q    <= 1'b0;
            err_oe_q     <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            on_cnt_q     <= on_cnt_d;
            pix_valid_q  <= pix_valid_d;
            pix_col_q    <= pix_col_d;
            pix_rgb_q    <= pix_rgb_d;
            line_valid_q <= line_valid_d;
            line_row_q   <= line_row_d;
            line_count_q <= line_count_d;
            on_cycles_q  <= on_cycles_d;
            err_len_q    <= err_len_d;
            err_oe_q     <= err_oe_d;
        end
    end

    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_col    = pix_col_q;
    assign bus.pix_rgb    = pix_rgb_q;
    assign bus.line_valid = line_valid_q;
    assign bus.line_row   = line_row_q;
    assign bus.line_count = line_count_q;
    assign bus.on_cycles  = on_cycles_q;
    assign bus.err_len    = err_len_q;
    assign bus.err_oe     = err_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_rx_monitor
//  Description : Randomized bench for hub75_rx_monitor with a transaction
//                level reference model (pixel and line scoreboards).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hub75_rx_monitor;

    localparam int COLS = 64;
    localparam int ON_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hub75_rx_monitor_if #(.ON_W(ON_W)) bus_if ();

    hub75_rx_monitor #(
        .COLS (COLS),
        .ON_W (ON_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    typedef struct {
        int col;
        int rgb;
    } pix_t;

    typedef struct {
        int cnt;
        int row;
        int elen;
        int eoe;
        int on;
        bit chk_on;
    } line_t;

    pix_t  pq[$];
    line_t lq[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: pixels seen in the current line, sticky flags, OE time
    int tb_col  = 0;
    bit st_len  = 1'b0;
    bit st_oe   = 1'b0;
    int tb_on   = 0;
    int on_base = 0;

    task automatic check(input string tag, input longint obs, input longint exp, input int tol = 0);
        longint d;
        n_checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
    endtask

    // Reference OE time: clk edges on which the panel drove OE low
    always @(posedge clk) begin
        if (rst_n && (bus_if.oe_in == 1'b0)) tb_on <= tb_on + 1;
    end

    // Scoreboard: compare every reported pixel / line with the model queues
    initial begin
        pix_t  p;
        line_t l;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (bus_if.pix_valid) begin
                    if (pq.size() == 0) begin
                        check("pix_unexpected", 1, 0);
                    end else begin
                        p = pq.pop_front();
                        check("pix_col", bus_if.pix_col, p.col);
                        check("pix_rgb", bus_if.pix_rgb, p.rgb);
                    end
                end
                if (bus_if.line_valid) begin
                    if (lq.size() == 0) begin
                        check("line_unexpected", 1, 0);
                    end else begin
                        l = lq.pop_front();
                        check("line_count", bus_if.line_count, l.cnt);
                        check("line_row", bus_if.line_row, l.row);
                        check("err_len", bus_if.err_len, l.elen);
                        check("err_oe", bus_if.err_oe, l.eoe);
                        if (l.chk_on) check("on_cycles", bus_if.on_cycles, l.on, 1);
                        check("pix_missing", pq.size(), 0);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive an hclk rising edge and record what the monitor should report
    task automatic hclk_rise();
        pix_t p;
        bus_if.hclk_in = 1'b1;
        if (tb_col < COLS) begin
            p.col = tb_col;
            p.rgb = int'(bus_if.rgb_in);
            pq.push_back(p);
        end
        if (tb_col <= COLS) tb_col++;
    endtask

    task automatic send_pixels(input int n, input bit rgb_is_col, input bit rnd_oe);
        for (int i = 0; i < n; i++) begin
            bus_if.hclk_in = 1'b0;
            bus_if.rgb_in  = rgb_is_col ? 6'(i) : 6'($urandom);
            bus_if.oe_in   = rnd_oe ? 1'($urandom) : 1'b1;
            tick($urandom_range(2, 4));
            hclk_rise();
            tick($urandom_range(2, 4));
        end
    endtask

    // Close the line; simul puts the final pixel edge in the latch cycle
    task automatic do_latch(input bit simul, input bit oe_low, input bit chk_on);
        line_t l;
        if (simul) begin
            bus_if.hclk_in = 1'b0;
            bus_if.rgb_in  = 6'($urandom);
            bus_if.oe_in   = 1'b1;
            tick(3);
            hclk_rise();
        end else if (!oe_low) begin
            bus_if.hclk_in = 1'b0;
            bus_if.oe_in   = 1'b1;
            tick(4);
        end
        bus_if.latch_in = 1'b1;
        l.cnt    = tb_col;
        l.row    = int'(bus_if.addr_in);
        l.elen   = int'(st_len | (tb_col != COLS));
        l.eoe    = int'(st_oe | oe_low);
        l.on     = tb_on - on_base;
        l.chk_on = chk_on;
        lq.push_back(l);
        st_len  = l.elen[0];
        st_oe   = l.eoe[0];
        on_base = tb_on;
        tb_col  = 0;
        tick(3);
        bus_if.hclk_in  = 1'b0;
        bus_if.latch_in = 1'b0;
        bus_if.oe_in    = 1'b1;
        tick(6);
    endtask

    task automatic pulse_err_clr();
        bus_if.err_clr = 1'b1;
        @(posedge clk);
        #1;
        check("err_len_clr", bus_if.err_len, 0);
        check("err_oe_clr", bus_if.err_oe, 0);
        @(negedge clk);
        bus_if.err_clr = 1'b0;
        st_len = 1'b0;
        st_oe  = 1'b0;
    endtask

    task automatic check_all_zero();
        check("rst_pix_valid", bus_if.pix_valid, 0);
        check("rst_pix_col", bus_if.pix_col, 0);
        check("rst_pix_rgb", bus_if.pix_rgb, 0);
        check("rst_line_valid", bus_if.line_valid, 0);
        check("rst_line_row", bus_if.line_row, 0);
        check("rst_line_count", bus_if.line_count, 0);
        check("rst_on_cycles", bus_if.on_cycles, 0);
        check("rst_err_len", bus_if.err_len, 0);
        check("rst_err_oe", bus_if.err_oe, 0);
    endtask

    initial begin
        bus_if.hclk_in  = 1'b0;
        bus_if.latch_in = 1'b0;
        bus_if.oe_in    = 1'b1;
        bus_if.rgb_in   = 6'd0;
        bus_if.addr_in  = 5'd0;
        bus_if.err_clr  = 1'b0;

        tick(4);
        check_all_zero();
        rst_n = 1'b1;
        on_base = tb_on;
        tick(4);

        // Full line, rgb = column; OE time after reset release is not modelled
        bus_if.addr_in = 5'd3;
        send_pixels(COLS, 1'b1, 1'b0);
        do_latch(1'b0, 1'b0, 1'b0);

        // Short line, then clear the length error
        bus_if.addr_in = 5'($urandom);
        send_pixels(COLS - 1, 1'b0, 1'b1);
        do_latch(1'b0, 1'b0, 1'b1);
        pulse_err_clr();

        // Long line: pixels beyond COLS are counted but not reported
        bus_if.addr_in = 5'($urandom);
        send_pixels(COLS + 6, 1'b0, 1'b1);
        do_latch(1'b0, 1'b0, 1'b1);

        // OE low for 100 cycles, latch while still low
        bus_if.addr_in = 5'($urandom);
        bus_if.oe_in   = 1'b0;
        tick(100);
        do_latch(1'b0, 1'b1, 1'b1);
        pulse_err_clr();

        // Last pixel and latch in the same cycle, next line restarts at col 0
        bus_if.addr_in = 5'($urandom);
        send_pixels(COLS - 1, 1'b0, 1'b1);
        do_latch(1'b1, 1'b0, 1'b1);
        bus_if.addr_in = 5'($urandom);
        send_pixels(COLS, 1'b0, 1'b1);
        do_latch(1'b0, 1'b0, 1'b1);

        // Random lines around the nominal width
        for (int k = 0; k < 6; k++) begin
            int n;
            bit s;
            n = $urandom_range(COLS - 3, COLS + 3);
            s = 1'($urandom);
            bus_if.addr_in = 5'($urandom);
            if (s) begin
                send_pixels(n - 1, 1'b0, 1'b1);
                do_latch(1'b1, 1'b0, 1'b1);
            end else begin
                send_pixels(n, 1'b0, 1'b1);
                do_latch(1'b0, 1'b0, 1'b1);
            end
        end

        // Reset in the middle of a line after a long (erroring) line
        bus_if.addr_in = 5'($urandom);
        send_pixels(COLS + 2, 1'b0, 1'b0);
        do_latch(1'b0, 1'b0, 1'b1);
        send_pixels(30, 1'b0, 1'b0);
        bus_if.hclk_in = 1'b0;
        tick(6);
        rst_n = 1'b0;
        tick(2);
        check_all_zero();
        pq.delete();
        lq.delete();
        tb_col = 0;
        st_len = 1'b0;
        st_oe  = 1'b0;
        rst_n  = 1'b1;
        on_base = tb_on;
        tick(2);
        bus_if.addr_in = 5'($urandom);
        send_pixels(COLS, 1'b0, 1'b0);
        do_latch(1'b0, 1'b0, 1'b0);

        tick(20);
        check("pix_queue_drained", pq.size(), 0);
        check("line_queue_drained", lq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
